// File: rtl/can_frame_tx_encoder_if.sv
// can_frame_tx_encoder_if: request/payload inputs and strobed word output of the CAN frame encoder
interface can_frame_tx_encoder_if;
  logic        req1, req2, req3;
  logic [11:0] d1, d2, d3, d4, d5, d6;
  logic [15:0] d7;
  logic [15:0] word_out;
  logic        cs_out, busy, frame_done, id_warn;
  modport master (
    output req1, req2, req3, d1, d2, d3, d4, d5, d6, d7,
    input  word_out, cs_out, busy, frame_done, id_warn
  );
  modport slave (
    input  req1, req2, req3, d1, d2, d3, d4, d5, d6, d7,
    output word_out, cs_out, busy, frame_done, id_warn
  );
endinterface

// File: rtl/can_frame_tx_encoder.sv
// can_frame_tx_encoder: serialises up to three CAN frame payloads into a cs-strobed 16-bit word stream.
// Define AUTO_TX_EN to add a free-running timer that requests all three frames every AUTO_PERIOD cycles.
module can_frame_tx_encoder #(
  parameter logic [15:0] ID1 = 16'd513,
  parameter logic [15:0] ID2 = 16'd514,
  parameter logic [15:0] ID3 = 16'd515,
  parameter int CS_LOW_CYC = 2,
  parameter int CS_HIGH_CYC = 2
`ifdef AUTO_TX_EN
  , parameter int AUTO_PERIOD = 50000
`endif
) (
  input logic clk,
  input logic rst,
  can_frame_tx_encoder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, SETUP, STROBE, DONE} state_t;
  localparam logic [7:0] LOW_M1 = 8'(CS_LOW_CYC - 1);
  localparam logic [7:0] HIGH_M1 = 8'(CS_HIGH_CYC - 1);
  state_t state, state_n;
  logic [2:0] pending, pending_n, req, auto_set, pick;
  logic [1:0] sel, sel_n, widx, widx_n, last;
  logic [7:0] cnt, cnt_n;
  logic [3:0][15:0] snap, snap_n;
  logic [15:0] word_q, word_n;
  logic cs_q, cs_n;
  assign req = {bus.req3, bus.req2, bus.req1};
  assign pick = pending & (~pending + 3'd1);
  assign last = (sel == 2'd2) ? 2'd1 : 2'd3;
  assign bus.word_out = word_q;
  assign bus.cs_out = cs_q;
  assign bus.busy = state != IDLE;
  assign bus.frame_done = state == DONE;
  assign bus.id_warn = state == LOAD && sel == 2'd2 && (bus.d7 == ID1 || bus.d7 == ID2 || bus.d7 == ID3);
`ifdef AUTO_TX_EN
  localparam int AW = $clog2(AUTO_PERIOD + 1);
  logic [AW-1:0] acnt;
  logic wrap;
  assign wrap = acnt == AW'(AUTO_PERIOD - 1);
  assign auto_set = {3{wrap}};
  always_ff @(posedge clk or posedge rst)
    if (rst) acnt <= '0;
    else acnt <= wrap ? '0 : acnt + 1'b1;
`else
  assign auto_set = 3'b000;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pending <= '0;
      sel <= '0;
      widx <= '0;
      cnt <= '0;
      snap <= '0;
      word_q <= '0;
      cs_q <= 1'b0;
    end else begin
      state <= state_n;
      pending <= pending_n;
      sel <= sel_n;
      widx <= widx_n;
      cnt <= cnt_n;
      snap <= snap_n;
      word_q <= word_n;
      cs_q <= cs_n;
    end
  // Slot 0 of the snapshot holds the ID word so word_out is always snap[widx].
  always_comb begin
    state_n = state;
    pending_n = pending | req | auto_set;
    sel_n = sel;
    widx_n = widx;
    cnt_n = cnt;
    snap_n = snap;
    word_n = word_q;
    cs_n = cs_q;
    case (state)
      IDLE:
        if (|pending) begin
          state_n = LOAD;
          sel_n = pick[0] ? 2'd0 : pick[1] ? 2'd1 : 2'd2;
          pending_n = (pending & ~pick) | req | auto_set;
        end
      LOAD: begin
        snap_n = (sel == 2'd0) ? {{4'h3, bus.d3}, {4'h2, bus.d2}, {4'h1, bus.d1}, ID1} :
                 (sel == 2'd1) ? {{4'h3, bus.d6}, {4'h2, bus.d5}, {4'h1, bus.d4}, ID2} :
                                 {32'h0, bus.d7, ID3};
        word_n = snap_n[0];
        widx_n = 2'd0;
        cnt_n = 8'd0;
        state_n = SETUP;
      end
      SETUP: begin
        cnt_n = cnt + 8'd1;
        if (cnt == LOW_M1) begin
          cnt_n = 8'd0;
          cs_n = 1'b1;
          state_n = STROBE;
        end
      end
      STROBE: begin
        cnt_n = cnt + 8'd1;
        if (cnt == HIGH_M1) begin
          cnt_n = 8'd0;
          cs_n = 1'b0;
          if (widx == last) state_n = DONE;
          else begin
            widx_n = widx + 2'd1;
            word_n = snap[widx + 2'd1];
            state_n = SETUP;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule
